pdm_audio_out: RTL

- Mono audio output path for the board amplifier; the transmit-direction counterpart of the microphone PDM capture path.
- Accepts signed PCM samples over a valid/ready handshake and sigma-delta modulates them to a 1-bit PDM stream on the audio output pin.
- Lives entirely in the 12.288 MHz audio clock domain.
- Manages amplifier shutdown and an anti-pop warm-up period.

---
 rtl/pdm_audio_out_if.sv | 11 +
 rtl/pdm_audio_out.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_out_if.sv
// PCM sample stream into the PDM audio output path: AXI-Stream-style valid/ready.
interface pdm_audio_out_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/pdm_audio_out.sv
// Mono PCM -> 1-bit PDM audio output with amplifier shutdown and anti-pop warm-up.
// Optional build macro PDM_SECOND_ORDER_EN selects a saturating second-order modulator.
module pdm_audio_out #(
  parameter int DIV          = 4,
  parameter int OSR          = 64,
  parameter int WIDTH        = 16,
  parameter int WARM_SAMPLES = 256
) (
  input  logic                 clk_12m288,
  input  logic                 resetn,
  input  logic                 enable,
  pdm_audio_out_if.slave       s,
  output logic                 aud_pwm,
  output logic                 aud_sd,
  output logic                 underrun
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSR_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int WARM_W = (WARM_SAMPLES > 1) ? $clog2(WARM_SAMPLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OSR_W-1:0]  OSR_LAST  = OSR_W'(OSR - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WARM_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] active_q, active_d;
  logic                    hold_full_q, hold_full_d;
  logic                    tready_q, tready_d;
  logic                    pwm_q, pwm_d;
  logic                    sd_q, sd_d;
  logic                    under_q, under_d;

  logic bit_tick;
  logic sample_tick;
  logic accept;

  assign bit_tick    = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
  assign sample_tick = bit_tick && (bit_cnt_q == OSR_LAST);
  assign accept      = s.s_tvalid && tready_q;

`ifdef PDM_SECOND_ORDER_EN
  localparam int IW = WIDTH + 4;
  localparam logic signed [IW+1:0] FB_POS = {{(IW+2-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW+1:0] FB_NEG = -FB_POS;

  logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic signed [IW-1:0] i1_n, i2_n;
  logic signed [IW+1:0] x_w, fb_w;

  // Clamp a two-bit-headroom sum back to the integrator width.
  function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW+1:0] v);
    if ((v[IW+1:IW-1] == 3'b000) || (v[IW+1:IW-1] == 3'b111))
      sat_iw = v[IW-1:0];
    else if (v[IW+1])
      sat_iw = {1'b1, {(IW-1){1'b0}}};
    else
      sat_iw = {1'b0, {(IW-1){1'b1}}};
  endfunction

  assign x_w  = {{(IW+2-WIDTH){active_q[WIDTH-1]}}, active_q};
  assign fb_w = pwm_q ? FB_POS : FB_NEG;
  assign i1_n = sat_iw({{2{i1_q[IW-1]}}, i1_q} + x_w - fb_w);
  assign i2_n = sat_iw({{2{i2_q[IW-1]}}, i2_q} + {{2{i1_n[IW-1]}}, i1_n} - fb_w);
`else
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] u_w;
  logic [WIDTH:0]   acc_sum;

  // Offset-binary view of the sample: midscale input gives 50% ones density.
  assign u_w     = {~active_q[WIDTH-1], active_q[WIDTH-2:0]};
  assign acc_sum = {1'b0, acc_q} + {1'b0, u_w};
`endif

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    hold_d      = hold_q;
    active_d    = active_q;
    hold_full_d = hold_full_q;
    pwm_d       = pwm_q;
    under_d     = 1'b0;
`ifdef PDM_SECOND_ORDER_EN
    i1_d        = i1_q;
    i2_d        = i2_q;
`else
    acc_d       = acc_q;
`endif

    if (state_q != ST_IDLE) begin
      div_cnt_d = bit_tick ? '0 : div_cnt_q + DIV_W'(1);
      if (bit_tick)
        bit_cnt_d = (bit_cnt_q == OSR_LAST) ? '0 : bit_cnt_q + OSR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        active_d = '0;
        if (sample_tick) begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = ST_RUN;
            warm_cnt_d = '0;
          end
        end
      end
      ST_RUN: begin
        // Ready is low while hold is full, so a load and an accept never coincide.
        if (sample_tick) begin
          if (hold_full_q) begin
            active_d    = hold_q;
            hold_full_d = 1'b0;
          end else begin
            under_d = 1'b1;
          end
        end
        if (accept) begin
          hold_d      = s.s_tdata;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bit_tick) begin
`ifdef PDM_SECOND_ORDER_EN
      i1_d  = i1_n;
      i2_d  = i2_n;
      pwm_d = ~i2_n[IW-1];
`else
      acc_d = acc_sum[WIDTH-1:0];
      pwm_d = acc_sum[WIDTH];
`endif
    end

    // Leaving for (or staying in) IDLE abandons everything in flight.
    if (!enable) state_d = ST_IDLE;
    if (state_d == ST_IDLE) begin
      div_cnt_d   = '0;
      bit_cnt_d   = '0;
      warm_cnt_d  = '0;
      hold_d      = '0;
      active_d    = '0;
      hold_full_d = 1'b0;
      pwm_d       = 1'b0;
      under_d     = 1'b0;
`ifdef PDM_SECOND_ORDER_EN
      i1_d        = '0;
      i2_d        = '0;
`else
      acc_d       = '0;
`endif
    end

    sd_d     = (state_d != ST_IDLE);
    tready_d = (state_d == ST_RUN) && !hold_full_d;
  end

  always_ff @(posedge clk_12m288 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      warm_cnt_q  <= '0;
      hold_q      <= '0;
      active_q    <= '0;
      hold_full_q <= 1'b0;
      tready_q    <= 1'b0;
      pwm_q       <= 1'b0;
      sd_q        <= 1'b0;
      under_q     <= 1'b0;
`ifdef PDM_SECOND_ORDER_EN
      i1_q        <= '0;
      i2_q        <= '0;
`else
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      hold_q      <= hold_d;
      active_q    <= active_d;
      hold_full_q <= hold_full_d;
      tready_q    <= tready_d;
      pwm_q       <= pwm_d;
      sd_q        <= sd_d;
      under_q     <= under_d;
`ifdef PDM_SECOND_ORDER_EN
      i1_q        <= i1_d;
      i2_q        <= i2_d;
`else
      acc_q       <= acc_d;
`endif
    end
  end

  assign s.s_tready = tready_q;
  assign aud_pwm    = pwm_q;
  assign aud_sd     = sd_q;
  assign underrun   = under_q;

endmodule
